// File: rtl/instr_issuer.sv
// instr_issuer
// -----------------------------------------------------------------------------
// Packs decoded instruction fields into the processor's 32-bit instruction
// word, queues the words in a small FIFO and issues at most one word per slot.
// After each issue, at least ISSUE_GAP idle slots follow before the next one.
// Idle slots drive the all-zero word: the processor treats opcode 0 as invalid.
//
// Handshake: a field set is taken at a rising edge when in_valid && in_ready.
// in_ready is !full only. It never anticipates a pop in the same cycle.
// The issue side has no back-pressure: the processor cannot stall.
//
// Parameters
//   DEPTH      FIFO entries, power of two, 2..16
//   ISSUE_GAP  idle cycles forced between consecutive issues, 0..15
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready field-set handshake
//   in_opcode[5:0], in_src1[4:0], in_src2[4:0], in_dest[4:0]  decoded fields
//   instruction[31:0] registered word to the processor, 0 when idle
//   issue             high while instruction holds a real instruction
//   level             FIFO occupancy
//   drop_cnt[7:0]     saturating count of rejected field sets
//
// Optional feature: define ILLEGAL_FILTER_EN to drop opcodes outside 4..14
// at the input. The handshake still completes for a dropped field set.
// Without the macro every accepted field set is queued, and drop_cnt is 0.
// -----------------------------------------------------------------------------
module instr_issuer #(
   parameter int DEPTH     = 4,
   parameter int ISSUE_GAP = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               in_opcode,
   input  logic [4:0]               in_src1,
   input  logic [4:0]               in_src2,
   input  logic [4:0]               in_dest,
   output logic [31:0]              instruction,
   output logic                     issue,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               drop_cnt
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [3:0]  GAP_LOAD = 4'(ISSUE_GAP);

   // Pointers carry one extra wrap bit so that full and empty can be told apart.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [3:0]   gap_q, gap_d;
   logic [31:0]  instr_q, instr_d;
   logic         issue_q, issue_d;

   logic [31:0]  mem_q [DEPTH];

   logic         full;
   logic         empty;
   logic         accept;
   logic         wr_en;
   logic         slot_open;
   logic [31:0]  packed_word;

   assign packed_word = {11'b0, in_dest, in_src2, in_src1, in_opcode};

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign accept = in_valid && !full;

`ifdef ILLEGAL_FILTER_EN
   logic        legal;
   logic [7:0]  drop_q, drop_d;

   assign legal = (in_opcode >= 6'd4) && (in_opcode <= 6'd14);
   assign wr_en = accept && legal;

   always_comb begin
      drop_d = drop_q;
      if (accept && !legal && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 8'h00;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign wr_en    = accept;
   assign drop_cnt = 8'h00;
`endif

   // The head word is read from registered state only. A word written in an
   // empty cycle becomes visible to the slot logic one edge later (no bypass).
   assign slot_open = !empty && (gap_q == 4'd0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      gap_d    = gap_q;
      instr_d  = 32'h0;
      issue_d  = 1'b0;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (slot_open) begin
         instr_d  = mem_q[rd_ptr_q[AW-1:0]];
         issue_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + 1'b1;
         gap_d    = GAP_LOAD;
      end else if (gap_q != 4'd0) begin
         gap_d = gap_q - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         gap_q    <= 4'd0;
         instr_q  <= 32'h0;
         issue_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         gap_q    <= gap_d;
         instr_q  <= instr_d;
         issue_q  <= issue_d;
      end
   end

   // Storage is deliberately not reset. The pointers alone define which
   // entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= packed_word;
      end
   end

   assign in_ready    = !full;
   assign instruction = instr_q;
   assign issue       = issue_q;
   assign level       = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer. Three instances share the field inputs:
//   u_dut_g0  (ISSUE_GAP 0), u_dut_g2 (ISSUE_GAP 2), u_dut_g15 (ISSUE_GAP 15).
// Each instance has its own in_valid, so only one is driven at a time.
module tb_instr_issuer;

   logic         clk;
   logic         rst_n;
   logic [2:0]   in_valid;
   logic [2:0]   rdy;
   logic [2:0]   iss;
   logic [5:0]   op;
   logic [4:0]   s1, s2, dst;
   logic [31:0]  instr [3];
   logic [2:0]   lvl   [3];
   logic [7:0]   drp   [3];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_iss [3] = '{0, 0, 0};

   logic [31:0] exp0_q [$];
   logic [31:0] exp1_q [$];
   logic [31:0] exp2_q [$];
   int          cyc1_q [$];
   int          cyc2_q [$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   instr_issuer #(.DEPTH(4), .ISSUE_GAP(0)) u_dut_g0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
      .in_opcode(op), .in_src1(s1), .in_src2(s2), .in_dest(dst),
      .instruction(instr[0]), .issue(iss[0]), .level(lvl[0]), .drop_cnt(drp[0]));

   instr_issuer #(.DEPTH(4), .ISSUE_GAP(2)) u_dut_g2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
      .in_opcode(op), .in_src1(s1), .in_src2(s2), .in_dest(dst),
      .instruction(instr[1]), .issue(iss[1]), .level(lvl[1]), .drop_cnt(drp[1]));

   instr_issuer #(.DEPTH(4), .ISSUE_GAP(15)) u_dut_g15 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]),
      .in_opcode(op), .in_src1(s1), .in_src2(s2), .in_dest(dst),
      .instruction(instr[2]), .issue(iss[2]), .level(lvl[2]), .drop_cnt(drp[2]));

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pack_word(input logic [5:0] o, input logic [4:0] a,
                                             input logic [4:0] b, input logic [4:0] d);
      return {11'b0, d, b, a, o};
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0:       return exp0_q.size();
         1:       return exp1_q.size();
         default: return exp2_q.size();
      endcase
   endfunction

   task automatic push_exp(input int k, input logic [31:0] w);
      case (k)
         0:       exp0_q.push_back(w);
         1:       exp1_q.push_back(w);
         default: exp2_q.push_back(w);
      endcase
   endtask

   task automatic pop_check(input int k, input logic [31:0] act);
      logic [31:0] e;
      int          sz;
      sz = qsize(k);
      check("exp_q_nonempty", 32'(sz != 0), 32'd1);
      if (sz != 0) begin
         case (k)
            0:       e = exp0_q.pop_front();
            1:       e = exp1_q.pop_front();
            default: e = exp2_q.pop_front();
         endcase
         check("issued_word", act, e);
      end
   endtask

   // ---------------- driver ----------------
   task automatic push(input int k, input logic [5:0] o, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d);
      int   t;
      logic legal;
      op = o; s1 = a; s2 = b; dst = d;
      in_valid[k] = 1'b1;
      t = 0;
      while (!rdy[k] && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) check("push_ready_wait", 32'(rdy[k]), 32'd1);
      @(posedge clk);
`ifdef ILLEGAL_FILTER_EN
      legal = (o >= 6'd4) && (o <= 6'd14);
`else
      legal = 1'b1;
`endif
      if (legal) push_exp(k, pack_word(o, a, b, d));
      #1;
      in_valid[k] = 1'b0;
   endtask

   task automatic wait_drain(input int k, input int maxc);
      int t;
      t = 0;
      while (qsize(k) != 0 && t < maxc) begin
         @(negedge clk);
         t++;
      end
      check("drain", 32'(qsize(k)), 32'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (iss[k]) begin
               n_iss[k]++;
               if (k == 1) cyc1_q.push_back(cyc);
               if (k == 2) cyc2_q.push_back(cyc);
               pop_check(k, instr[k]);
            end else begin
               check("idle_word_zero", instr[k], 32'h0);
            end
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      int base;
      rst_n = 1'b0;
      in_valid = 3'b000;
      op = '0; s1 = '0; s2 = '0; dst = '0;
      #3;
      for (int k = 0; k < 3; k++) begin
         check("rst_instr", instr[k], 32'h0);
         check("rst_issue", 32'(iss[k]), 32'd0);
         check("rst_ready", 32'(rdy[k]), 32'd1);
         check("rst_level", 32'(lvl[k]), 32'd0);
         check("rst_drop",  32'(drp[k]), 32'd0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single push, minimum latency, ISSUE_GAP 0.
      push(0, 6'd6, 5'd1, 5'd2, 5'd3);
      check("lat_edge_n_issue", 32'(iss[0]), 32'd0);
      @(posedge clk); #1;
      check("lat_edge_n1_issue", 32'(iss[0]), 32'd1);
      check("lat_edge_n1_word", instr[0], 32'h0003_1046);
      @(posedge clk); #1;
      check("lat_after_issue", 32'(iss[0]), 32'd0);
      check("lat_after_word", instr[0], 32'h0);

      // Fill while the slot is closed (ISSUE_GAP 15, after one issue).
      cyc2_q.delete();
      push(2, 6'd8, 5'd9, 5'd10, 5'd11);
      begin
         int t;
         t = 0;
         while (!iss[2] && t < 10) begin
            @(negedge clk);
            t++;
         end
         check("fill_first_issue", 32'(iss[2]), 32'd1);
      end
      for (int i = 0; i < 4; i++) begin
         push(2, 6'(4 + i), 5'(i), 5'(i + 10), 5'(i + 20));
      end
      check("fill_ready_low", 32'(rdy[2]), 32'd0);
      check("fill_level4", 32'(lvl[2]), 32'd4);
      op = 6'd5; s1 = 5'd31; s2 = 5'd31; dst = 5'd31;
      in_valid[2] = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("fill_fifth_level", 32'(lvl[2]), 32'd4);
      end
      in_valid[2] = 1'b0;
      wait_drain(2, 120);
      check("fill_issue_count", 32'(cyc2_q.size()), 32'd5);
      for (int i = 1; i < cyc2_q.size(); i++) begin
         check("gap15_spacing", 32'(cyc2_q[i] - cyc2_q[i-1]), 32'd16);
      end
      repeat (20) @(negedge clk);

      // Burst of 3 with ISSUE_GAP 2.
      cyc1_q.delete();
      push(1, 6'd9,  5'd1, 5'd1, 5'd1);
      push(1, 6'd10, 5'd2, 5'd2, 5'd2);
      push(1, 6'd11, 5'd3, 5'd3, 5'd3);
      wait_drain(1, 50);
      repeat (3) @(negedge clk);
      check("gap2_issue_count", 32'(cyc1_q.size()), 32'd3);
      for (int i = 1; i < cyc1_q.size(); i++) begin
         check("gap2_spacing", 32'(cyc1_q[i] - cyc1_q[i-1]), 32'd3);
      end

      // Back-to-back push and issue at level 1, past pointer wrap.
      base = n_iss[0];
      for (int i = 0; i < 21; i++) begin
         push(0, 6'($urandom_range(4, 14)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         check("b2b_level", 32'(lvl[0]), 32'd1);
      end
      wait_drain(0, 20);
      repeat (2) @(negedge clk);
      check("b2b_count", 32'(n_iss[0] - base), 32'd21);

      // Illegal-opcode filter.
      base = n_iss[0];
      push(0, 6'd3,  5'd1, 5'd2, 5'd3);
      push(0, 6'd15, 5'd4, 5'd5, 5'd6);
      push(0, 6'd4,  5'd7, 5'd8, 5'd9);
      push(0, 6'd14, 5'd10, 5'd11, 5'd12);
      wait_drain(0, 20);
      repeat (2) @(negedge clk);
`ifdef ILLEGAL_FILTER_EN
      check("filter_count", 32'(n_iss[0] - base), 32'd2);
      check("filter_drop", 32'(drp[0]), 32'd2);
`else
      check("filter_count", 32'(n_iss[0] - base), 32'd4);
      check("filter_drop", 32'(drp[0]), 32'd0);
`endif

      // Asynchronous reset with level 3 and a running gap count.
      for (int i = 0; i < 4; i++) begin
         push(2, 6'(5 + i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
      end
      push(0, 6'd12, 5'd13, 5'd14, 5'd15);
      @(posedge clk); #3;
      check("pre_rst_issue", 32'(iss[0]), 32'd1);
      check("pre_rst_level", 32'(lvl[2]), 32'd3);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("async_rst_instr", instr[k], 32'h0);
         check("async_rst_issue", 32'(iss[k]), 32'd0);
         check("async_rst_ready", 32'(rdy[k]), 32'd1);
         check("async_rst_level", 32'(lvl[k]), 32'd0);
      end
      exp0_q.delete();
      exp1_q.delete();
      exp2_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(2, 6'd7, 5'd4, 5'd5, 5'd6);
      check("post_rst_edge_n", 32'(iss[2]), 32'd0);
      @(posedge clk); #1;
      check("post_rst_issue", 32'(iss[2]), 32'd1);
      check("post_rst_word", instr[2], 32'h0006_2907);
      wait_drain(2, 10);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Instruction encoder and issue buffer on the producer side of the processor's 32-bit instruction port. Accepts decoded fields (opcode, src1, src2, dest) over a valid/ready handshake and packs them into the processor instruction format. Buffers them in a small FIFO and presents one instruction per issue slot, with a programmable minimum spacing. Idle slots carry the all-zero word, whose opcode 0 the processor treats as invalid, so no register write occurs.

## Interface

- DEPTH, 4: FIFO entries; power of two, 2..16.
- ISSUE_GAP, 0: idle cycles forced between consecutive issued instructions, 0..15.
- clk input 1: the single clock; all state updates on its rising edge.
- rst_n input 1: reset, asynchronous and active-low.
- in_valid input 1: producer presents a field set this cycle.
- in_ready output 1: issuer can accept; equals !full.
- in_opcode input 6: operation code.
- in_src1 input 5: first source register.
- in_src2 input 5: second source register.
- in_dest input 5: destination register.
- instruction output 32: packed word to the processor; 32'h0 when idle.
- issue output 1: high in the cycle `instruction` holds a real instruction.
- level output $clog2(DEPTH)+1: current FIFO occupancy.
- drop_cnt output 8: count of rejected field sets (see Configuration).

## Operation

- Packing: instruction = {11'b0, dest[4:0], src2[4:0], src1[4:0], opcode[5:0]}, so opcode sits at [5:0], src1 at [10:6], src2 at [15:11] and dest at [20:16]. Bits [31:21] are always 0.
- Accept: when in_valid && in_ready at a rising edge, the packed word is written at the write pointer and the write pointer increments.
- in_ready depends only on full. It does not look ahead to a same-cycle pop.
- Issue slot open: FIFO not empty and gap counter == 0.
- On an open slot:
  - The head word is registered onto `instruction` and issue is set to 1.
  - The read pointer increments.
  - The gap counter loads ISSUE_GAP.
- Otherwise:
  - `instruction` is registered to 32'h0 and issue to 0.
  - The gap counter decrements if it is nonzero.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
  - level = wr_ptr − rd_ptr.
- Simultaneous accept and issue in the same cycle:
  - level is unchanged.
  - Legal when full: in_ready is 0, so no accept happens, and the pop proceeds.
  - When empty, the word written this cycle is not issuable until the next edge, so there is no bypass.
- drop_cnt saturates at 8'hFF.
- Gap counter and FIFO contents do not depend on downstream state. The processor has no stall input.

## Timing

- Reset (rst_n low, asynchronous): instruction = 32'h0, issue = 0, in_ready = 1, level = 0, drop_cnt = 0, pointers = 0, gap counter = 0.
  - FIFO storage is not reset.
  - Release is synchronous to the next rising edge. The first accept is possible at the first rising edge with rst_n high.
- Latency: a field set accepted at edge N appears on instruction/issue after edge N+1 at the earliest, when the FIFO was empty and the gap counter was 0.
- Throughput: one instruction every ISSUE_GAP+1 cycles while the FIFO is non-empty.
- Reset mid-operation clears queued entries and any in-progress gap count. instruction drops to 0 immediately, without waiting for a clock edge.
- Inputs are sampled only on a handshake edge. Changing fields while in_valid is low has no effect.

## Configuration

- ILLEGAL_FILTER_EN defined: opcodes outside 4..14 are rejected at the input.
  - in_ready still reflects !full, and the handshake completes.
  - The word is not written to the FIFO, and drop_cnt increments.
- ILLEGAL_FILTER_EN undefined: every accepted field set is queued and issued unchanged.
  - The processor ignores illegal opcodes itself.
  - drop_cnt is tied to 8'h00.

## Test plan

- Reset then single push (opcode 6, src1 1, src2 2, dest 3) with ISSUE_GAP 0: instruction = 32'h0003_1046 with issue=1 on the second edge after the push; then instruction = 0 and issue = 0.
- Fill with DEPTH 4 while no slot is open (ISSUE_GAP 15, after one issue): after 4 accepts, in_ready=0 and level=4. A fifth in_valid is not accepted. Entries then issue in push order.
- Burst of 3 pushes with ISSUE_GAP 2: issue pulses are exactly 3 cycles apart. Idle cycles show instruction=0.
- Back-to-back push and issue with the FIFO at level 1 for 20 cycles: level stays at 1 and no entry is lost or duplicated. Cover pointer wrap past 2·DEPTH.
- ILLEGAL_FILTER_EN defined, push opcodes 3, 15, 4, 14: only 4 and 14 issue and drop_cnt=2. Undefined: all four issue and drop_cnt=0.
- Assert rst_n low asynchronously while level=3 and the gap counter is nonzero: outputs take their reset values before the next edge. After release, the first push issues with minimum latency.
